draw_rect_sync: RTL

- Downstream consumer of the rectangle-position controller's xpos/ypos.
- Overlays a solid rectangle with a one-pixel border onto the VGA timing/colour stream. The stream enters from the background stage and leaves toward the mouse overlay stage.
- Position is sampled once per frame, at the start of vertical blanking, so a moving or falling rectangle never tears mid-frame.
- Fixed two-cycle pipeline: every timing signal is delayed in step with the colour.

---
 rtl/vga_pkg.sv | 7 +
 rtl/vga_delay.sv | 21 ++
 rtl/draw_rect_sync.sv | 84 ++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA stream widths and default visible-area sizes.
package vga_pkg;
  localparam int CNT_W = 11;
  localparam int RGB_W = 12;
  localparam int H_ACTIVE_DEF = 1024;
  localparam int V_ACTIVE_DEF = 768;
endpackage

// File: rtl/vga_delay.sv
// vga_delay: fixed-depth register delay line with async active-low clear.
module vga_delay #(
  parameter int W = 1,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] r [D];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) r[i] <= '0;
    end else begin
      r[0] <= d;
      for (int i = 1; i < D; i++) r[i] <= r[i-1];
    end
  end
  assign q = r[D-1];
endmodule

// File: rtl/draw_rect_sync.sv
// draw_rect_sync: overlays a bordered rectangle on the VGA stream, position latched at vblank start.
module draw_rect_sync
  import vga_pkg::*;
#(
  parameter int          RECT_W     = 48,
  parameter int          RECT_H     = 64,
  parameter logic [11:0] RECT_RGB   = 12'hF80,
  parameter logic [11:0] BORDER_RGB = 12'hFFF,
  parameter int          H_ACTIVE   = H_ACTIVE_DEF,
  parameter int          V_ACTIVE   = V_ACTIVE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [11:0]      xpos,
  input  logic [11:0]      ypos,
  input  logic [CNT_W-1:0] hcount_in,
  input  logic [CNT_W-1:0] vcount_in,
  input  logic             hsync_in,
  input  logic             hblnk_in,
  input  logic             vsync_in,
  input  logic             vblnk_in,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [CNT_W-1:0] hcount_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic             vsync_out,
  output logic             vblnk_out,
  output logic [RGB_W-1:0] rgb_out
);
  logic             vblnk_prev;
  logic [11:0]      x_lat, y_lat;
  logic [12:0]      hc, vc, x0, y0, x1, y1;
  logic             in_x, in_y, on_edge, visible;
  logic [RGB_W-1:0] rgb_s1;
  logic             in_rect_s1, on_edge_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_prev <= 1'b0;
      x_lat      <= '0;
      y_lat      <= '0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (vblnk_in && !vblnk_prev) begin
        x_lat <= xpos;
        y_lat <= ypos;
      end
    end
  end

  // 13-bit extents: a rectangle near 4095 runs off-screen instead of wrapping
  assign hc      = {2'b00, hcount_in};
  assign vc      = {2'b00, vcount_in};
  assign x0      = {1'b0, x_lat};
  assign y0      = {1'b0, y_lat};
  assign x1      = x0 + 13'(RECT_W - 1);
  assign y1      = y0 + 13'(RECT_H - 1);
  assign in_x    = (hc >= x0) && (hc <= x1);
  assign in_y    = (vc >= y0) && (vc <= y1);
  assign on_edge = in_x && in_y && (hc == x0 || hc == x1 || vc == y0 || vc == y1);
  assign visible = (hc < 13'(H_ACTIVE)) && (vc < 13'(V_ACTIVE)) && !hblnk_in && !vblnk_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_s1     <= '0;
      in_rect_s1 <= 1'b0;
      on_edge_s1 <= 1'b0;
      rgb_out    <= '0;
    end else begin
      rgb_s1     <= rgb_in;
      in_rect_s1 <= in_x && in_y && visible;
      on_edge_s1 <= on_edge;
      rgb_out    <= in_rect_s1 ? (on_edge_s1 ? BORDER_RGB : RECT_RGB) : rgb_s1;
    end
  end

  vga_delay #(.W(2 * CNT_W + 4), .D(2)) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in}),
    .q     ({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out})
  );
endmodule
